mvm_sequencer: RTL and testbench

Control sequencer for the layer matrix-vector-multiply datapath (weight ROM, bias ROM, input-vector memory, multiplier pipe register, bias/accumulate mux, accumulator register with ReLU output). It accepts an N-element input vector over a valid/ready stream and writes it into the vector memory. For each of M output rows it issues weight, bias and vector addresses and the accumulator controls, then presents each row result on a valid/ready output handshake. It sits between the upstream stream source, the datapath, and the downstream consumer.

---
 rtl/mvm_sequencer_if.sv | 39 +++
 rtl/mvm_sequencer.sv | 136 +++++++++++++
 tb/tb_mvm_sequencer.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/mvm_sequencer_if.sv
// mvm_sequencer_if: bundle of the sequencer's stream handshakes and datapath
// control lines.
//   s_valid/s_ready   : upstream vector-element stream
//   m_valid/m_ready   : downstream row-result handshake
//   wr_en_x, addr_X   : vector memory write enable / shared address
//   addr_W, addr_B    : weight and bias ROM addresses
//   accum_src, en     : accumulator source select and enable
//   busy, layer_done  : status
// master = sequencer side, slave = environment/datapath side.
interface mvm_sequencer_if #(
  parameter int WA = 9,
  parameter int BA = 5,
  parameter int XA = 5
);
  logic          s_valid;
  logic          s_ready;
  logic          m_valid;
  logic          m_ready;
  logic          wr_en_x;
  logic [XA-1:0] addr_X;
  logic [WA-1:0] addr_W;
  logic [BA-1:0] addr_B;
  logic          accum_src;
  logic          en;
  logic          busy;
  logic          layer_done;

  modport master (
    input  s_valid, m_ready,
    output s_ready, m_valid, wr_en_x, addr_X, addr_W, addr_B,
           accum_src, en, busy, layer_done
  );

  modport slave (
    output s_valid, m_ready,
    input  s_ready, m_valid, wr_en_x, addr_X, addr_W, addr_B,
           accum_src, en, busy, layer_done
  );
endinterface

// File: rtl/mvm_sequencer.sv
// mvm_sequencer: control sequencer for the layer matrix-vector-multiply
// datapath. Loads an N-element vector from the upstream stream into the
// vector memory, then for each of M rows drives weight/bias/vector
// addresses and accumulator controls and presents the row result on a
// valid/ready handshake.
//   clk   : rising-edge clock
//   reset : asynchronous, active-low reset
//   bus   : mvm_sequencer_if.master (stream, result handshake, datapath
//           controls, status)
module mvm_sequencer #(
  parameter int M  = 8,
  parameter int N  = 10,
  parameter int WA = 9,
  parameter int BA = 5,
  parameter int XA = 5
) (
  input  logic                 clk,
  input  logic                 reset,
  mvm_sequencer_if.master      bus
);

  typedef enum logic [1:0] {IDLE, LOAD, COMPUTE, OUT} state_t;

  localparam logic [XA-1:0] NM1_X = XA'(N - 1);
  localparam logic [XA-1:0] NP1_X = XA'(N + 1);
  localparam logic [WA-1:0] N_W   = WA'(N);
  localparam logic [WA-1:0] NM1_W = WA'(N - 1);
  localparam logic [BA-1:0] MM1_B = BA'(M - 1);

  state_t        st, st_n;
  logic [XA-1:0] lc, lc_n;
  logic [XA-1:0] p, p_n;
  logic [BA-1:0] r, r_n;

  logic [XA-1:0] p_clamp;
  logic [WA-1:0] row_base;

  // Vector index stops at N-1 once the reads for the last element are out;
  // the remaining phases only drain the read and multiplier pipeline.
  always_comb begin
    p_clamp  = (p > NM1_X) ? NM1_X : p;
    row_base = WA'(r) * N_W;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      st <= IDLE;
      lc <= '0;
      p  <= '0;
      r  <= '0;
    end else begin
      st <= st_n;
      lc <= lc_n;
      p  <= p_n;
      r  <= r_n;
    end
  end

  always_comb begin
    st_n           = st;
    lc_n           = lc;
    p_n            = p;
    r_n            = r;
    bus.s_ready    = 1'b0;
    bus.m_valid    = 1'b0;
    bus.wr_en_x    = 1'b0;
    bus.addr_X     = '0;
    bus.addr_W     = '0;
    bus.addr_B     = '0;
    bus.accum_src  = 1'b0;
    bus.en         = 1'b0;
    bus.busy       = 1'b0;
    bus.layer_done = 1'b0;

    unique case (st)
      IDLE: begin
        st_n = LOAD;
      end

      LOAD: begin
        bus.s_ready = 1'b1;
        bus.wr_en_x = bus.s_valid;
        bus.addr_X  = lc;
        if (bus.s_valid) begin
          if (lc == NM1_X) begin
            lc_n = '0;
            r_n  = '0;
            p_n  = '0;
            st_n = COMPUTE;
          end else begin
            lc_n = lc + 1'b1;
          end
        end
      end

      COMPUTE: begin
        bus.busy      = 1'b1;
        bus.addr_X    = p_clamp;
        bus.addr_W    = row_base + WA'(p_clamp);
        bus.addr_B    = r;
        // p==1: bias arrives from its 1-cycle ROM read and seeds the
        // accumulator; p>=2: products arrive two cycles after their address.
        bus.en        = (p != '0);
        bus.accum_src = (p == XA'(1));
        if (p == NP1_X) begin
          st_n = OUT;
        end else begin
          p_n = p + 1'b1;
        end
      end

      OUT: begin
        bus.busy    = 1'b1;
        bus.m_valid = 1'b1;
        bus.addr_B  = r;
        bus.addr_W  = row_base + NM1_W;
        if (bus.m_ready) begin
          p_n = '0;
          if (r == MM1_B) begin
            bus.layer_done = 1'b1;
            r_n            = '0;
            st_n           = LOAD;
          end else begin
            r_n  = r + 1'b1;
            st_n = COMPUTE;
          end
        end
      end

      default: begin
        st_n = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_mvm_sequencer.sv
// tb_mvm_sequencer: randomized self-checking bench for mvm_sequencer.
// A behavioural datapath (ROMs, vector memory, 1-cycle reads, multiplier
// pipe, accumulator) is driven by the DUT controls; row results are
// compared against ReLU(B[r] + sum W[r*N+k]*x[k]) computed directly.
module tb_mvm_sequencer;
  localparam int M  = 8;
  localparam int N  = 10;
  localparam int WA = 9;
  localparam int BA = 5;
  localparam int XA = 5;

  logic clk = 1'b0;
  logic reset;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;
  int   ld_count = 0;

  mvm_sequencer_if #(.WA(WA), .BA(BA), .XA(XA)) bus();

  mvm_sequencer #(.M(M), .N(N), .WA(WA), .BA(BA), .XA(XA)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (bus.layer_done) ld_count <= ld_count + 1;

  // Behavioural datapath
  int     W [M*N];
  int     B [M];
  int     x_mem [1<<XA];
  int     xv [N];
  int     x_data;
  int     w_q, x_q, b_q;
  longint prod_q, acc;

  initial begin
    w_q = 0; x_q = 0; b_q = 0; prod_q = 0; acc = 0;
    foreach (x_mem[i]) x_mem[i] = 0;
  end

  always @(posedge clk) begin
    if (bus.wr_en_x) x_mem[bus.addr_X] <= x_data;
    w_q    <= W[bus.addr_W];
    x_q    <= x_mem[bus.addr_X];
    b_q    <= B[bus.addr_B];
    prod_q <= longint'(w_q) * longint'(x_q);
    if (bus.en) acc <= bus.accum_src ? longint'(b_q) : acc + prod_q;
  end

  function automatic longint data_out();
    return (acc < 0) ? 0 : acc;
  endfunction

  function automatic longint exp_row(input int r);
    longint s;
    s = B[r];
    for (int k = 0; k < N; k++) s += longint'(W[r*N+k]) * longint'(xv[k]);
    return (s < 0) ? 0 : s;
  endfunction

  function automatic longint all_outs();
    logic [63:0] v;
    v = '0;
    v[27:0] = {bus.s_ready, bus.m_valid, bus.wr_en_x, bus.addr_X, bus.addr_W,
               bus.addr_B, bus.accum_src, bus.en, bus.busy, bus.layer_done};
    return longint'(v);
  endfunction

  task automatic check(input string tag, input longint obs, input longint exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Entered in LOAD with inputs drivable; returns at the cycle after the last beat.
  task automatic load_vec(input bit alt);
    int gaps;
    for (int i = 0; i < N; i++) begin
      gaps = alt ? 1 : int'($urandom_range(0, 2));
      for (int g = 0; g < gaps; g++) begin
        bus.s_valid = 1'b0;
        #1;
        check("gap_wr_en", bus.wr_en_x, 0);
        check("gap_s_ready", bus.s_ready, 1);
        tick();
      end
      bus.s_valid = 1'b1;
      x_data = int'($urandom_range(0, 200)) - 100;
      xv[i]  = x_data;
      #1;
      check("beat_wr_en", bus.wr_en_x, 1);
      check("beat_addr_X", bus.addr_X, i);
      check("load_m_valid", bus.m_valid, 0);
      check("load_busy", bus.busy, 0);
      tick();
    end
    bus.s_valid = 1'b1; // ignored outside LOAD
  endtask

  task automatic compute_phase(input int r, input int last_p);
    int pc;
    for (int p = 0; p <= last_p; p++) begin
      bus.m_ready = 1'b1; // must not complete anything while computing
      #1;
      pc = (p > N-1) ? N-1 : p;
      check("c_s_ready", bus.s_ready, 0);
      check("c_wr_en", bus.wr_en_x, 0);
      check("c_m_valid", bus.m_valid, 0);
      check("c_busy", bus.busy, 1);
      check("c_addr_W", bus.addr_W, r*N + pc);
      check("c_addr_X", bus.addr_X, pc);
      check("c_addr_B", bus.addr_B, r);
      check("c_en", bus.en, (p >= 1) ? 1 : 0);
      check("c_accum_src", bus.accum_src, (p == 1) ? 1 : 0);
      check("c_layer_done", bus.layer_done, 0);
      tick();
    end
    bus.m_ready = 1'b0;
  endtask

  int prev_hs;
  bit spacing_on;

  task automatic out_phase(input int r, input int hold);
    for (int h = 0; h < hold; h++) begin
      bus.m_ready = 1'b0;
      #1;
      check("bp_m_valid", bus.m_valid, 1);
      check("bp_en", bus.en, 0);
      check("bp_addr_B", bus.addr_B, r);
      check("bp_addr_W", bus.addr_W, r*N + N-1);
      check("bp_data", data_out(), exp_row(r));
      check("bp_layer_done", bus.layer_done, 0);
      tick();
    end
    bus.m_ready = 1'b1;
    #1;
    check("hs_m_valid", bus.m_valid, 1);
    check("hs_data", data_out(), exp_row(r));
    check("hs_layer_done", bus.layer_done, (r == M-1) ? 1 : 0);
    if (spacing_on && r > 0) check("hs_spacing", cyc - prev_hs, N + 3);
    prev_hs = cyc;
    tick();
    bus.m_ready = 1'b0;
  endtask

  task automatic run_layer(input bit alt, input int hold0, input bit rand_hold);
    ld_count = 0;
    load_vec(alt);
    for (int r = 0; r < M; r++) begin
      compute_phase(r, N+1);
      out_phase(r, (r == 0) ? hold0 : (rand_hold ? int'($urandom_range(0, 3)) : 0));
    end
    #1;
    check("post_s_ready", bus.s_ready, 1);
    check("post_busy", bus.busy, 0);
    check("layer_done_count", ld_count, 1);
  endtask

  initial begin
    foreach (W[i]) W[i] = int'($urandom_range(0, 200)) - 100;
    foreach (B[i]) B[i] = int'($urandom_range(0, 8000)) - 4000;
    x_data      = 0;
    reset       = 1'b0;
    bus.s_valid = 1'b1;
    bus.m_ready = 1'b1;
    spacing_on  = 1'b0;
    prev_hs     = 0;

    // Reset held 3 cycles with inputs active: everything gated to 0
    for (int i = 0; i < 3; i++) begin
      tick();
      check("rst_outs", all_outs(), 0);
    end
    bus.s_valid = 1'b0;
    bus.m_ready = 1'b0;
    reset = 1'b1;
    #1;
    check("idle_outs", all_outs(), 0);
    tick();
    check("first_s_ready", bus.s_ready, 1);

    // Layer 1: alternating load, 7-cycle backpressure on row 0, random holds
    run_layer(1'b1, 7, 1'b1);

    // Layer 2: random gaps, m_ready effectively tied high
    spacing_on = 1'b1;
    run_layer(1'b0, 0, 1'b0);
    spacing_on = 1'b0;

    // Layer 3: reset at p=5 of row 3
    foreach (W[i]) W[i] = int'($urandom_range(0, 200)) - 100;
    load_vec(1'b0);
    for (int r = 0; r < 3; r++) begin
      compute_phase(r, N+1);
      out_phase(r, 0);
    end
    compute_phase(3, 4);
    bus.m_ready = 1'b1;
    reset = 1'b0;
    #1;
    check("mid_rst_outs", all_outs(), 0);
    tick();
    check("mid_rst_hold", all_outs(), 0);
    tick();
    bus.m_ready = 1'b0;
    reset = 1'b1;
    #1;
    check("mid_idle_outs", all_outs(), 0);
    tick();
    check("mid_s_ready", bus.s_ready, 1);
    check("mid_m_valid", bus.m_valid, 0);
    run_layer(1'b0, 2, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
